memory_arbiter: RTL and testbench

Parametrised N-port arbiter sharing one single-port synchronous memory between several requesters (instruction fetch, data load/store, DMA, debug). It replaces fixed time-slot alternation with request-driven round-robin arbitration, a per-port ready handshake and tagged read-response return. The block sits between the core-side memory clients and the single memory macro.

---
 rtl/memory_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin N-port arbiter in front of one single-port
// synchronous memory. Grants are combinational. Read responses come back
// through a tag pipeline that is READ_LAT stages deep, so each read returns
// to the port that issued it.
// Optional build macro MEMORY_ARBITER_PROBE_EN adds two debug outputs:
// grant_prob (registered copy of req_ready) and rr_ptr_prob (the round-robin pointer).
module memory_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef MEMORY_ARBITER_PROBE_EN
    output logic [NUM_PORTS-1:0]          grant_prob,
    output logic [$clog2(NUM_PORTS)-1:0]  rr_ptr_prob,
`endif
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]          req_read_en,
    input  logic [NUM_PORTS-1:0]          req_write_en,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_write_val,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   rsp_read_val,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_read_en,
    output logic                          mem_write_en,
    input  logic [DATA_W-1:0]             mem_read_val,
    output logic [DATA_W-1:0]             mem_write_val
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_a;
    logic [NUM_PORTS-1:0]             req;
    logic [PW-1:0]                    rr_ptr;
    logic [PW-1:0]                    gidx;
    logic                             found;
    logic                             rd_issue;

    logic [READ_LAT-1:0]              vld_pipe;
    logic [READ_LAT-1:0][PW-1:0]      tag_pipe;

    // Advance a port index by k, wrapping at NUM_PORTS. NUM_PORTS need not be a power of 2.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    // Split the flat per-port buses into indexed lanes.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_write_val[i*DATA_W +: DATA_W];
    end

    // Round-robin search: start at rr_ptr and wrap upward; the first requesting port wins.
    always_comb begin
        req   = req_read_en | req_write_en;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                gidx  = wrap_add(rr_ptr, k);
            end
        end
    end

    // Steer the winner onto the memory bus. If read and write are both set, the write wins.
    always_comb begin
        req_ready       = '0;
        req_ready[gidx] = found;
        mem_addr        = found ? addr_a[gidx] : '0;
        mem_write_en    = found & req_write_en[gidx];
        rd_issue        = found & req_read_en[gidx] & ~req_write_en[gidx];
        mem_read_en     = rd_issue;
        mem_write_val   = mem_write_en ? wdata_a[gidx] : '0;
    end

    // Move the pointer to the port after the winner. If nothing was granted, keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rr_ptr <= '0;
        else if (found) rr_ptr <= wrap_add(gidx, 1);
    end

    // Tag pipeline: a {valid, port} pair for each cycle of memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            tag_pipe[0] <= gidx;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Capture memory data into the owning port's slot and pulse rsp_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= '0;
            rsp_read_val <= '0;
        end else begin
            rsp_valid <= '0;
            if (vld_pipe[READ_LAT-1]) begin
                rsp_valid[tag_pipe[READ_LAT-1]] <= 1'b1;
                rsp_read_val[tag_pipe[READ_LAT-1]*DATA_W +: DATA_W] <= mem_read_val;
            end
        end
    end

`ifdef MEMORY_ARBITER_PROBE_EN
    // Debug trace: grant vector delayed by one cycle, plus the live pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_prob <= '0;
        else        grant_prob <= req_ready;
    end
    assign rr_ptr_prob = rr_ptr;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter. There are two instances:
//   u2: NUM_PORTS=2, READ_LAT=1 (table-driven arbitration, mux and response checks)
//   u3: NUM_PORTS=3, READ_LAT=3 (rotation under full load, reset while reads are in flight)
module tb_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance u2 ----------------
    logic        rst2;
    logic [15:0] a2;
    logic [1:0]  rd2, wr2, rdy2, rv2;
    logic [63:0] wv2, rsp2;
    logic [7:0]  ma2;
    logic        mrd2, mwr2;
    logic [31:0] mrv2, mwv2, p2;
    logic [31:0] mem2 [256];
`ifdef MEMORY_ARBITER_PROBE_EN
    logic [1:0]  gp2;
    logic [0:0]  rp2;
`endif

    memory_arbiter #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .READ_LAT(1)) u2 (
        .clk(clk), .rst_n(rst2),
`ifdef MEMORY_ARBITER_PROBE_EN
        .grant_prob(gp2), .rr_ptr_prob(rp2),
`endif
        .req_addr(a2), .req_read_en(rd2), .req_write_en(wr2), .req_write_val(wv2),
        .req_ready(rdy2), .rsp_valid(rv2), .rsp_read_val(rsp2),
        .mem_addr(ma2), .mem_read_en(mrd2), .mem_write_en(mwr2),
        .mem_read_val(mrv2), .mem_write_val(mwv2)
    );

    // Memory model with 1-cycle read latency.
    always @(posedge clk) begin
        if (mwr2) mem2[ma2] <= mwv2;
        p2 <= mrd2 ? mem2[ma2] : 32'h0;
    end
    assign mrv2 = p2;

    // ---------------- instance u3 ----------------
    logic        rst3;
    logic [23:0] a3;
    logic [2:0]  rd3, wr3, rdy3, rv3;
    logic [95:0] wv3, rsp3;
    logic [7:0]  ma3;
    logic        mrd3, mwr3;
    logic [31:0] mrv3, mwv3;
    logic [31:0] p3 [3];
    logic [31:0] mem3 [256];
`ifdef MEMORY_ARBITER_PROBE_EN
    logic [2:0]  gp3;
    logic [1:0]  rp3;
`endif

    memory_arbiter #(.NUM_PORTS(3), .ADDR_W(8), .DATA_W(32), .READ_LAT(3)) u3 (
        .clk(clk), .rst_n(rst3),
`ifdef MEMORY_ARBITER_PROBE_EN
        .grant_prob(gp3), .rr_ptr_prob(rp3),
`endif
        .req_addr(a3), .req_read_en(rd3), .req_write_en(wr3), .req_write_val(wv3),
        .req_ready(rdy3), .rsp_valid(rv3), .rsp_read_val(rsp3),
        .mem_addr(ma3), .mem_read_en(mrd3), .mem_write_en(mwr3),
        .mem_read_val(mrv3), .mem_write_val(mwv3)
    );

    // Memory model with 3-cycle read latency.
    always @(posedge clk) begin
        if (mwr3) mem3[ma3] <= mwv3;
        p3[0] <= mrd3 ? mem3[ma3] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mrv3 = p3[2];

    // ---------------- u2 vector table ----------------
    typedef struct {
        logic [1:0]  rd, wr;
        logic [7:0]  a0, a1;
        logic [1:0]  rdy;
        logic [7:0]  maddr;
        logic        mrd, mwr;
        logic [31:0] mwv;
        logic [1:0]  rsp;
        logic        cs;      // check one response slot
        logic        cp;      // which slot
        logic [31:0] cv;      // expected slot contents
    } vec_t;

    vec_t tbl [12];

    initial begin
        int p;
        int ec;
        logic [2:0] eg, er, eg_prev;

        for (int i = 0; i < 256; i++) begin
            mem2[i] = 32'h1000_0000 | i;
            mem3[i] = 32'hB000_0000 | i;
        end
        mem2[8'h10] = 32'hDEADBEEF;

        // Vectors are applied one per cycle. Expected values account for rr_ptr history.
        //            rd     wr     a0     a1     rdy    maddr  mrd mwr mwv            rsp    cs  cp  cv
        tbl[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 32'h0,         2'b00, 0, 0, 32'h0};
        tbl[1]  = '{2'b10, 2'b00, 8'h00, 8'h10, 2'b10, 8'h10, 1, 0, 32'h0,         2'b00, 0, 0, 32'h0};
        tbl[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 32'h0,         2'b00, 0, 0, 32'h0};
        tbl[3]  = '{2'b00, 2'b01, 8'h20, 8'h00, 2'b01, 8'h20, 0, 1, 32'h5A5A5A5A,  2'b10, 1, 1, 32'hDEADBEEF};
        tbl[4]  = '{2'b10, 2'b00, 8'h00, 8'h20, 2'b10, 8'h20, 1, 0, 32'h0,         2'b00, 0, 0, 32'h0};
        tbl[5]  = '{2'b11, 2'b00, 8'h30, 8'h40, 2'b01, 8'h30, 1, 0, 32'h0,         2'b00, 0, 0, 32'h0};
        tbl[6]  = '{2'b11, 2'b00, 8'h30, 8'h40, 2'b10, 8'h40, 1, 0, 32'h0,         2'b10, 1, 1, 32'h5A5A5A5A};
        tbl[7]  = '{2'b01, 2'b01, 8'h30, 8'h00, 2'b01, 8'h30, 0, 1, 32'h5A5A5A5A,  2'b01, 1, 0, 32'h10000030};
        tbl[8]  = '{2'b01, 2'b10, 8'h50, 8'h60, 2'b10, 8'h60, 0, 1, 32'hC3C3C3C3,  2'b10, 1, 1, 32'h10000040};
        tbl[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 32'h0,         2'b00, 1, 0, 32'h10000030};
        tbl[10] = '{2'b00, 2'b11, 8'h70, 8'h71, 2'b01, 8'h70, 0, 1, 32'h5A5A5A5A,  2'b00, 0, 0, 32'h0};
        tbl[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0, 32'h0,         2'b00, 1, 0, 32'h10000030};

        rst2 = 1'b0; rst3 = 1'b0;
        a2 = '0; rd2 = '0; wr2 = '0; wv2 = {32'hC3C3C3C3, 32'h5A5A5A5A};
        a3 = '0; rd3 = '0; wr3 = '0; wv3 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy2",  64'(rdy2), 64'h0);
        chk("rst_rv2",   64'(rv2),  64'h0);
        chk("rst_slot2", 64'(rsp2), 64'h0);
        chk("rst_ma2",   64'(ma2),  64'h0);
        chk("rst_mrd2",  64'(mrd2), 64'h0);
        chk("rst_mwr2",  64'(mwr2), 64'h0);
        chk("rst_mwv2",  64'(mwv2), 64'h0);
        chk("rst_rv3",   64'(rv3),  64'h0);
        chk("rst_slot3", 128'(rsp3), 128'h0);
`ifdef MEMORY_ARBITER_PROBE_EN
        chk("rst_gp2", 64'(gp2), 64'h0);
        chk("rst_rp2", 64'(rp2), 64'h0);
`endif
        tick();
        rst2 = 1'b1; rst3 = 1'b1;

        // Table-driven pass on u2
        for (int i = 0; i < 12; i++) begin
            tick();
            rd2 = tbl[i].rd;
            wr2 = tbl[i].wr;
            a2  = {tbl[i].a1, tbl[i].a0};
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 64'(rdy2), 64'(tbl[i].rdy));
            chk($sformatf("v%0d_maddr", i), 64'(ma2), 64'(tbl[i].maddr));
            chk($sformatf("v%0d_mrd", i), 64'(mrd2), 64'(tbl[i].mrd));
            chk($sformatf("v%0d_mwr", i), 64'(mwr2), 64'(tbl[i].mwr));
            chk($sformatf("v%0d_mwv", i), 64'(mwv2), 64'(tbl[i].mwv));
            chk($sformatf("v%0d_rsp", i), 64'(rv2), 64'(tbl[i].rsp));
            if (tbl[i].cs)
                chk($sformatf("v%0d_slot%0d", i, tbl[i].cp),
                    64'(tbl[i].cp ? rsp2[63:32] : rsp2[31:0]), 64'(tbl[i].cv));
`ifdef MEMORY_ARBITER_PROBE_EN
            chk($sformatf("v%0d_gprob", i), 64'(gp2), 64'(i == 0 ? 2'b00 : tbl[i-1].rdy));
`endif
        end
        rd2 = '0; wr2 = '0;

        // u3: all three ports read continuously for 9 cycles, then stop
        eg_prev = '0;
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c < 9) begin
                rd3 = 3'b111;
                a3  = {8'h03, 8'h02, 8'h01};
            end else begin
                rd3 = 3'b000;
                a3  = '0;
            end
            eg = (c < 9) ? 3'(1 << (c % 3)) : 3'b000;
            er = (c >= 4 && c - 4 < 9) ? 3'(1 << ((c - 4) % 3)) : 3'b000;
            @(negedge clk);
            chk($sformatf("rot%0d_rdy", c), 64'(rdy3), 64'(eg));
            chk($sformatf("rot%0d_maddr", c), 64'(ma3), 64'(c < 9 ? (c % 3) + 1 : 0));
            chk($sformatf("rot%0d_rsp", c), 64'(rv3), 64'(er));
            if (er != 0) begin
                p = (c - 4) % 3;
                chk($sformatf("rot%0d_slot%0d", c, p), 64'(rsp3[p*32 +: 32]), 64'(32'hB000_0000 | (p + 1)));
            end
`ifdef MEMORY_ARBITER_PROBE_EN
            chk($sformatf("rot%0d_gprob", c), 64'(gp3), 64'(eg_prev));
            chk($sformatf("rot%0d_rrptr", c), 64'(rp3), 64'(c < 9 ? c % 3 : 0));
`endif
            eg_prev = eg;
        end

        // u3: back-to-back reads on ports 0 and 1, then reset while both are in flight
        tick();
        rd3 = 3'b001; a3 = {8'h00, 8'h06, 8'h05};
        @(negedge clk);
        chk("rstfl_g0", 64'(rdy3), 64'(3'b001));
        tick();
        rd3 = 3'b010;
        @(negedge clk);
        chk("rstfl_g1", 64'(rdy3), 64'(3'b010));
        tick();
        rd3 = 3'b000; a3 = '0; rst3 = 1'b0;
        @(negedge clk);
        chk("rstfl_slots_in_rst", 128'(rsp3), 128'h0);
        ec = 0;
        for (int d = 0; d < 8; d++) begin
            if (d == 2) begin
                tick();
                rst3 = 1'b1;
                @(negedge clk);
            end else if (d != 0) begin
                @(negedge clk);
            end
            if (rv3 != 3'b000) ec++;
        end
        chk("rstfl_no_rsp", 64'(ec), 64'h0);
        chk("rstfl_slots_after", 128'(rsp3), 128'h0);
`ifdef MEMORY_ARBITER_PROBE_EN
        chk("rstfl_rrptr", 64'(rp3), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
